// File: rtl/sv_stream_feeder_pkg.sv
// Shared parameters, FSM encoding and address-width helper for the SV stream feeder.
package sv_stream_feeder_pkg;

  localparam int XLEN_PIXEL_DEF    = 8;
  localparam int NUM_OF_PIXELS_DEF = 4;
  localparam int NUM_OF_SV_DEF     = 87;
  localparam int STATS_W           = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } feed_state_t;

  // A single-entry ROM still needs a 1-bit address bus.
  function automatic int aw_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sv_stream_feeder_addr_gen.sv
// Linear pixel/SV/ROM address counters for the stream feeder; advance on i_en, wrap at frame end.
module sv_stream_feeder_addr_gen
  import sv_stream_feeder_pkg::*;
#(
  parameter int NUM_OF_PIXELS = NUM_OF_PIXELS_DEF,
  parameter int NUM_OF_SV     = NUM_OF_SV_DEF,
  parameter int PX_AW         = 2,
  parameter int AL_AW         = 7,
  parameter int SV_AW         = 9
)(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [PX_AW-1:0] o_pix_idx,
  output logic [AL_AW-1:0] o_sv_idx,
  output logic [SV_AW-1:0] o_lin_addr,
  output logic             o_first_pix,
  output logic             o_last_pix,
  output logic             o_last_sv
);

  localparam logic [PX_AW-1:0] PIX_MAX = PX_AW'(NUM_OF_PIXELS - 1);
  localparam logic [AL_AW-1:0] SV_MAX  = AL_AW'(NUM_OF_SV - 1);

  logic [PX_AW-1:0] r_pix;
  logic [AL_AW-1:0] r_sv;
  logic [SV_AW-1:0] r_lin;
  logic             w_last_pix;
  logic             w_last_sv;

  assign w_last_pix = (r_pix == PIX_MAX);
  assign w_last_sv  = (r_sv == SV_MAX);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pix <= '0;
      r_sv  <= '0;
      r_lin <= '0;
    end else if (i_clr) begin
      r_pix <= '0;
      r_sv  <= '0;
      r_lin <= '0;
    end else if (i_en) begin
      // Running linear address avoids an sv*NUM_OF_PIXELS multiply.
      if (w_last_pix) begin
        r_pix <= '0;
        r_sv  <= w_last_sv ? '0 : r_sv + AL_AW'(1);
        r_lin <= w_last_sv ? '0 : r_lin + SV_AW'(1);
      end else begin
        r_pix <= r_pix + PX_AW'(1);
        r_lin <= r_lin + SV_AW'(1);
      end
    end
  end

  assign o_pix_idx   = r_pix;
  assign o_sv_idx    = r_sv;
  assign o_lin_addr  = r_lin;
  assign o_first_pix = (r_pix == '0);
  assign o_last_pix  = w_last_pix;
  assign o_last_sv   = w_last_sv;

endmodule

// File: rtl/sv_stream_feeder.sv
// Streams test/SV pixels and alpha from sync ROMs to the HWF kernel, SV-major, one beat per clk.
// Optional FEEDER_STATS_EN adds a saturating hold-cycle counter output stall_cnt.
module sv_stream_feeder
  import sv_stream_feeder_pkg::*;
#(
  parameter  int XLEN_PIXEL    = XLEN_PIXEL_DEF,
  parameter  int NUM_OF_PIXELS = NUM_OF_PIXELS_DEF,
  parameter  int NUM_OF_SV     = NUM_OF_SV_DEF,
  localparam int SV_AW         = aw_min1(NUM_OF_SV * NUM_OF_PIXELS),
  localparam int PX_AW         = aw_min1(NUM_OF_PIXELS),
  localparam int AL_AW         = aw_min1(NUM_OF_SV)
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    hold_in,
  output logic                    mem_en,
  output logic [SV_AW-1:0]        sv_addr,
  input  logic [XLEN_PIXEL-1:0]   sv_rdata,
  output logic [PX_AW-1:0]        test_addr,
  input  logic [XLEN_PIXEL-1:0]   test_rdata,
  output logic [AL_AW-1:0]        alpha_addr,
  input  logic [2*XLEN_PIXEL-1:0] alpha_rdata,
  output logic [XLEN_PIXEL-1:0]   x_test,
  output logic [XLEN_PIXEL-1:0]   x_sv,
  output logic [2*XLEN_PIXEL-1:0] Bi,
  output logic                    stall_MEM,
  output logic                    sv_first,
  output logic                    sv_last,
  output logic                    busy,
`ifdef FEEDER_STATS_EN
  output logic [STATS_W-1:0]      stall_cnt,
`endif
  output logic                    done
);

  feed_state_t r_state, w_nxt;

  logic w_busy, w_mem_en, w_clr, w_adv, w_issue, w_done;
  logic w_first_pix, w_last_pix, w_last_sv;
  logic r_issued_all;

  // [0]: ROM data stage, [1]: output register stage
  logic [1:0] r_vld_pipe;
  logic       r_s1_first, r_s1_last, r_s1_final;
  logic       r_out_first, r_out_last, r_out_final;

  logic [XLEN_PIXEL-1:0]   r_x_test, r_x_sv;
  logic [2*XLEN_PIXEL-1:0] r_bi;

  sv_stream_feeder_addr_gen #(
    .NUM_OF_PIXELS (NUM_OF_PIXELS),
    .NUM_OF_SV     (NUM_OF_SV),
    .PX_AW         (PX_AW),
    .AL_AW         (AL_AW),
    .SV_AW         (SV_AW)
  ) u_addr_gen (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_clr       (w_clr),
    .i_en        (w_issue),
    .o_pix_idx   (test_addr),
    .o_sv_idx    (alpha_addr),
    .o_lin_addr  (sv_addr),
    .o_first_pix (w_first_pix),
    .o_last_pix  (w_last_pix),
    .o_last_sv   (w_last_sv)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt    = r_state;
    w_busy   = 1'b0;
    w_mem_en = 1'b0;
    w_clr    = 1'b0;
    w_adv    = 1'b0;
    w_issue  = 1'b0;
    w_done   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_nxt = ST_PRIME;
          w_clr = 1'b1;
        end
      end
      // PRIME's ROM read of address 0 is discarded; it only sets the pipeline depth.
      ST_PRIME: begin
        w_busy   = 1'b1;
        w_mem_en = ~hold_in;
        w_nxt    = ST_STREAM;
      end
      ST_STREAM: begin
        w_busy   = 1'b1;
        w_mem_en = ~hold_in;
        w_adv    = ~hold_in;
        w_issue  = ~hold_in & ~r_issued_all;
        if (~hold_in && r_vld_pipe[1] && r_out_final) w_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_done = 1'b1;
        w_nxt  = ST_IDLE;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issued_all <= 1'b0;
      r_vld_pipe   <= '0;
      r_s1_first   <= 1'b0;
      r_s1_last    <= 1'b0;
      r_s1_final   <= 1'b0;
      r_out_first  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_final  <= 1'b0;
      r_x_test     <= '0;
      r_x_sv       <= '0;
      r_bi         <= '0;
    end else begin
      if (w_clr)
        r_issued_all <= 1'b0;
      else if (w_issue && w_last_pix && w_last_sv)
        r_issued_all <= 1'b1;

      // Whole pipe advances in lockstep so a hold can never drop or repeat a beat.
      if (w_adv) begin
        r_vld_pipe  <= {r_vld_pipe[0], w_issue};
        r_s1_first  <= w_first_pix;
        r_s1_last   <= w_last_pix;
        r_s1_final  <= w_last_pix & w_last_sv;
        r_out_first <= r_vld_pipe[0] & r_s1_first;
        r_out_last  <= r_vld_pipe[0] & r_s1_last;
        r_out_final <= r_vld_pipe[0] & r_s1_final;
        if (r_vld_pipe[0]) begin
          r_x_test <= test_rdata;
          r_x_sv   <= sv_rdata;
          r_bi     <= alpha_rdata;
        end
      end
    end
  end

`ifdef FEEDER_STATS_EN
  logic [STATS_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (w_clr)
      r_stall_cnt <= '0;
    else if (w_busy && hold_in && (r_stall_cnt != {STATS_W{1'b1}}))
      r_stall_cnt <= r_stall_cnt + STATS_W'(1);
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign mem_en    = w_mem_en;
  assign busy      = w_busy;
  assign done      = w_done;
  assign stall_MEM = ~r_vld_pipe[1];
  assign sv_first  = r_out_first;
  assign sv_last   = r_out_last;
  assign x_test    = r_x_test;
  assign x_sv      = r_x_sv;
  assign Bi        = r_bi;

endmodule
